// File: rtl/pooling_ctrl.sv
// pooling_ctrl: pass sequencer for pooling_layer; strip requests, datapath enables and result tags.
// Optional stall counter output stall_cnt is enabled by defining POOL_CTRL_PERF_EN.
module pooling_ctrl #(
    parameter int W     = 32,
    parameter int K     = 2,
    parameter int S     = 2,
    parameter int depth = 1,
    parameter int W_P   = ((W - K) / S) + 1,
    parameter int CW    = (W_P > 1) ? $clog2(W_P) : 1,
    parameter int DW    = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] col_idx,
    output logic [DW-1:0] ch_idx,
    output logic          ctrl_Pool,
    output logic          max_avg_ctrl,
    output logic          out_valid,
    output logic [CW-1:0] out_col,
    output logic [DW-1:0] out_ch,
    output logic          busy,
    output logic          done
`ifdef POOL_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, col1_q, col2_q;
    logic [DW-1:0] ch_q, ch_d, ch1_q, ch2_q;
    logic          mode_q, mode_d, v1_q, v2_q, fire, col_end, last;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ch_d    = ch_q;
        mode_d  = mode_q;
        fire    = in_valid && state_q == RUN;
        col_end = col_q == CW'(W_P - 1);
        last    = col_end && ch_q == DW'(depth - 1);
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                mode_d  = mode;
                col_d   = '0;
                ch_d    = '0;
            end
            RUN: if (fire) begin
                col_d   = col_end ? '0 : col_q + CW'(1);
                ch_d    = last ? '0 : col_end ? ch_q + DW'(1) : ch_q;
                state_d = last ? DRAIN : RUN;
            end
            // v2 is loaded from v1 this edge, so v1 clear means both bits clear next cycle
            DRAIN: if (!v1_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            ch_q    <= '0;
            mode_q  <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            col1_q  <= '0;
            ch1_q   <= '0;
            col2_q  <= '0;
            ch2_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            mode_q  <= mode_d;
            v1_q    <= fire;
            v2_q    <= v1_q;
            col1_q  <= col_q;
            ch1_q   <= ch_q;
            col2_q  <= col1_q;
            ch2_q   <= ch1_q;
        end
    end

`ifdef POOL_CTRL_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start))
            stall_q <= '0;
        else if (state_q == RUN && !in_valid && !(&stall_q))
            stall_q <= stall_q + 32'd1;
    end
    assign stall_cnt = stall_q;
`endif

    assign in_ready     = state_q == RUN;
    assign busy         = state_q == RUN || state_q == DRAIN;
    assign done         = state_q == DONE;
    assign ctrl_Pool    = fire | v1_q;
    assign max_avg_ctrl = mode_q;
    assign out_valid    = v2_q;
    assign out_col      = col2_q;
    assign out_ch       = ch2_q;
    assign col_idx      = col_q;
    assign ch_idx       = ch_q;
endmodule
